// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the only arithmetic stage of the serial adder.
module full_adder (
    input  logic [2:0] inputs,
    output logic [1:0] outputs
);

    // Sum is the parity of the three bits; carry is their majority.
    always_comb begin
        outputs[0] = inputs[2] ^ inputs[1] ^ inputs[0];
        outputs[1] = (inputs[2] & inputs[1]) | (inputs[2] & inputs[0]) | (inputs[1] & inputs[0]);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in one bit per
// clock, LSB first, with a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic               carry;
    logic [CNT_W-1:0]   bit_cnt;
    logic [1:0]         fa_out;
    logic               accept;
    logic               last_bit;

    full_adder u_full_adder (
        .inputs  ({a_sr[0], b_sr[0], carry}),
        .outputs (fa_out)
    );

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == ADD);
    assign done     = (state == DONE);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start in DONE is accepted back-to-back like IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting and result latching.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            carry   <= cin;
            bit_cnt <= '0;
        end else if (state == ADD) begin
            carry   <= fa_out[1];
            sum_sr  <= {fa_out[0], sum_sr[WIDTH-1:1]};
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= {fa_out[0], sum_sr[WIDTH-1:1]};
                cout <= fa_out[1];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors;
    int checks;
    logic [W-1:0] last_sum;

    serial_adder #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    // 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference: plain unsigned addition, carry out of the MSB is bit W.
    function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) at negedges for done, counting busy cycles on the way.
    task automatic waitDone(output int busy_cycles, output logic seen);
        int n;
        busy_cycles = 0;
        n = 0;
        while (!done && n < 30) begin
            if (busy) busy_cycles++;
            n++;
            @(negedge clock);
        end
        seen = done;
    endtask

    // One full transaction: single-cycle start pulse, wait, check result.
    task automatic applyStimulus(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int bc;
        logic seen;
        logic [W:0] exp;
        exp = refAdd(x, y, c);
        @(negedge clock);
        a = x; b = y; cin = c; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a = ~x; b = ~y; cin = ~c;
        waitDone(bc, seen);
        checkOutput({tag, "_done"}, 32'(seen), 32'd1);
        checkOutput({tag, "_busylen"}, 32'(bc), 32'(W));
        checkOutput({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(exp[W]));
        @(negedge clock);
        checkOutput({tag, "_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_hold"}, 32'(sum), 32'(exp[W-1:0]));
        last_sum = exp[W-1:0];
    endtask

    initial begin
        int bc;
        int done_count;
        int last_done;
        logic seen;
        logic [W:0] q[$];
        logic [W:0] exp;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;

        errors = 0;
        checks = 0;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        reset_n = 1'b1;

        applyStimulus("t1", 8'h5A, 8'h3C, 1'b0);
        applyStimulus("t2", 8'hFF, 8'h01, 1'b0);
        applyStimulus("t3a", 8'hFF, 8'hFF, 1'b1);
        applyStimulus("t3b", 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus("rnd", W'($urandom), W'($urandom), 1'($urandom));
        end

        // Start while busy is ignored; old result held during the new ADD.
        @(negedge clock);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checkOutput("t4_heldsum", 32'(sum), 32'(last_sum));
        a = 8'hFF; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(bc, seen);
        checkOutput("t4_done", 32'(seen), 32'd1);
        checkOutput("t4_sum", 32'(sum), 32'h30);
        checkOutput("t4_cout", 32'(cout), 32'd0);
        done_count = 0;
        @(negedge clock);
        for (int i = 0; i < 15; i++) begin
            if (done || busy) done_count++;
            @(negedge clock);
        end
        checkOutput("t4_single", 32'(done_count), 32'd0);

        // Asynchronous reset during the 4th ADD cycle.
        a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("t5_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_done", 32'(done), 32'd0);
        checkOutput("t5_sum", 32'(sum), 32'd0);
        checkOutput("t5_cout", 32'(cout), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        done_count = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (done) done_count++;
        end
        checkOutput("t5_nodone", 32'(done_count), 32'd0);

        // Start held high: an accept every W+1 edges, each with its own operands.
        done_count = 0;
        last_done = -1;
        start = 1'b1;
        for (int c = 0; c <= 5 * (W + 1); c++) begin
            if (done) begin
                done_count++;
                if (q.size() == 0) begin
                    checkOutput("t6_extra", 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    checkOutput("t6_sum", 32'(sum), 32'(exp[W-1:0]));
                    checkOutput("t6_cout", 32'(cout), 32'(exp[W]));
                end
                if (last_done >= 0) checkOutput("t6_spacing", 32'(c - last_done), 32'(W + 1));
                last_done = c;
            end
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            a = ra; b = rb; cin = rc;
            if (c % (W + 1) == 0) q.push_back(refAdd(ra, rb, rc));
            @(negedge clock);
        end
        start = 1'b0;
        checkOutput("t6_count", 32'(done_count), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
